// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, with subnormal flush-to-zero and five rounding modes.
module fp_div_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [2:0]         rm_q, rm_d;
  logic               s_q, s_d;
  logic signed [9:0]  e_q, e_d;
  logic [25:0]        rem_q, rem_d;
  logic [25:0]        q_q, q_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        fp_z_q, fp_z_d;
  logic               ovrf_q, ovrf_d;
  logic               udrf_q, udrf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  // Operand classification and special-case results, taken straight from the inputs
  logic        x_zero_s, x_inf_s, x_nan_s;
  logic        y_zero_s, y_inf_s, y_nan_s;
  logic        sign_in_s;
  logic        spec_s;
  logic [31:0] spec_z_s;
  logic        spec_ovrf_s;

  always_comb begin
    x_zero_s    = (fp_X[30:23] == 8'd0);
    x_inf_s     = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] == 23'd0);
    x_nan_s     = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] != 23'd0);
    y_zero_s    = (fp_Y[30:23] == 8'd0);
    y_inf_s     = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] == 23'd0);
    y_nan_s     = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] != 23'd0);
    sign_in_s   = fp_X[31] ^ fp_Y[31];
    spec_s      = 1'b1;
    spec_z_s    = 32'd0;
    spec_ovrf_s = 1'b0;
    if (x_nan_s || y_nan_s || (x_zero_s && y_zero_s) || (x_inf_s && y_inf_s)) begin
      spec_z_s = 32'h7FC00000;
    end else if (x_inf_s) begin
      spec_z_s = {sign_in_s, 8'hFF, 23'd0};
    end else if (y_inf_s || x_zero_s) begin
      spec_z_s = {sign_in_s, 31'd0};
    end else if (y_zero_s) begin
      spec_z_s    = {sign_in_s, 8'hFF, 23'd0};
      spec_ovrf_s = 1'b1;
    end else begin
      spec_s = 1'b0;
    end
  end

  // Mantissa preparation and one restoring-division step
  logic [23:0]       mx_s, my_s;
  logic signed [9:0] e_prep_s;
  logic              ge_s;
  logic [25:0]       rem_sub_s;

  always_comb begin
    mx_s      = {1'b1, x_q[22:0]};
    my_s      = {1'b1, y_q[22:0]};
    e_prep_s  = $signed({2'b00, x_q[30:23]} - {2'b00, y_q[30:23]} + 10'd127);
    ge_s      = (rem_q >= {2'b00, my_s});
    if (ge_s) begin
      rem_sub_s = rem_q - {2'b00, my_s};
    end else begin
      rem_sub_s = rem_q;
    end
  end

  // Rounding of the 24-bit significand plus guard/round/sticky
  logic              g_s, r_s, st_s, inexact_s, inc_s, away_s;
  logic [24:0]       mant_inc_s;
  logic [22:0]       frac_s;
  logic signed [9:0] e_rnd_s;
  logic [31:0]       rnd_z_s;
  logic              rnd_ovrf_s, rnd_udrf_s;

  always_comb begin
    g_s       = q_q[1];
    r_s       = q_q[0];
    st_s      = (rem_q != 26'd0);
    inexact_s = g_s | r_s | st_s;
    case (rm_q)
      3'b001: begin
        inc_s  = 1'b0;
        away_s = 1'b0;
      end
      3'b010: begin
        inc_s  = s_q & inexact_s;
        away_s = s_q;
      end
      3'b011: begin
        inc_s  = ~s_q & inexact_s;
        away_s = ~s_q;
      end
      3'b100: begin
        inc_s  = g_s;
        away_s = 1'b1;
      end
      default: begin
        inc_s  = g_s & (r_s | st_s | q_q[2]);
        away_s = 1'b1;
      end
    endcase
    mant_inc_s = {1'b0, q_q[25:2]} + {24'd0, inc_s};
    if (mant_inc_s[24]) begin
      frac_s  = 23'd0;
      e_rnd_s = e_q + 10'sd1;
    end else begin
      frac_s  = mant_inc_s[22:0];
      e_rnd_s = e_q;
    end
    rnd_ovrf_s = 1'b0;
    rnd_udrf_s = 1'b0;
    if (e_rnd_s >= 10'sd255) begin
      rnd_ovrf_s = 1'b1;
      if (away_s) begin
        rnd_z_s = {s_q, 8'hFF, 23'd0};
      end else begin
        rnd_z_s = {s_q, 8'hFE, 23'h7FFFFF};
      end
    end else if (e_rnd_s <= 10'sd0) begin
      rnd_udrf_s = 1'b1;
      rnd_z_s    = {s_q, 31'd0};
    end else begin
      rnd_z_s = {s_q, e_rnd_s[7:0], frac_s};
    end
  end

  // Next-state and datapath update for the control FSM
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    rm_d        = rm_q;
    s_d         = s_q;
    e_d         = e_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    fp_z_d      = fp_z_q;
    ovrf_d      = ovrf_q;
    udrf_d      = udrf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          x_d        = fp_X;
          y_d        = fp_Y;
          rm_d       = r_mode;
          s_d        = sign_in_s;
          in_ready_d = 1'b0;
          if (spec_s) begin
            fp_z_d      = spec_z_s;
            ovrf_d      = spec_ovrf_s;
            udrf_d      = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_PREP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        // Pre-normalise so the quotient always lands in [1,2)
        if (mx_s < my_s) begin
          rem_d = {1'b0, mx_s, 1'b0};
          e_d   = e_prep_s - 10'sd1;
        end else begin
          rem_d = {2'b00, mx_s};
          e_d   = e_prep_s;
        end
        q_d     = 26'd0;
        cnt_d   = 5'(QBITS - 1);
        state_d = S_DIV;
      end
      S_DIV: begin
        q_d   = {q_q[24:0], ge_s};
        rem_d = {rem_sub_s[24:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_DIV;
        end
      end
      S_ROUND: begin
        fp_z_d      = rnd_z_s;
        ovrf_d      = rnd_ovrf_s;
        udrf_d      = rnd_udrf_s;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= 32'd0;
      y_q         <= 32'd0;
      rm_q        <= 3'd0;
      s_q         <= 1'b0;
      e_q         <= 10'sd0;
      rem_q       <= 26'd0;
      q_q         <= 26'd0;
      cnt_q       <= 5'd0;
      fp_z_q      <= 32'd0;
      ovrf_q      <= 1'b0;
      udrf_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rm_q        <= rm_d;
      s_q         <= s_d;
      e_q         <= e_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      fp_z_q      <= fp_z_d;
      ovrf_q      <= ovrf_d;
      udrf_q      <= udrf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign fp_Z      = fp_z_q;
  assign ovrf      = ovrf_q;
  assign udrf      = udrf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: expected results are queued at issue time and
// compared when the divider presents its output.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_x;
  logic [31:0] fp_y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_z;
  logic        ovrf;
  logic        udrf;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    string       tag;
    logic [31:0] z;
    logic        o;
    logic        u;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_div_seq #(.QBITS(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_x),
    .fp_Y      (fp_y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_z),
    .ovrf      (ovrf),
    .udrf      (udrf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation, wait for its result, compare, optionally stall, then hand off.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] rm, input logic [31:0] ez, input logic eo,
                       input logic eu, input int elat, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    logic [31:0] z0;
    e.tag = tag; e.z = ez; e.o = eo; e.u = eu; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    fp_x = x; fp_y = y; r_mode = rm; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    got = sb.pop_front();
    check({got.tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (got.lat > 0) check({got.tag, "_lat"}, lat, got.lat);
    check({got.tag, "_z"}, fp_z, got.z);
    check({got.tag, "_ovrf"}, {31'd0, ovrf}, {31'd0, got.o});
    check({got.tag, "_udrf"}, {31'd0, udrf}, {31'd0, got.u});
    z0 = fp_z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({got.tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({got.tag, "_hold_z"}, fp_z, z0);
      check({got.tag, "_hold_inready"}, {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({got.tag, "_handoff_valid"}, {31'd0, out_valid}, 32'd0);
    check({got.tag, "_handoff_inready"}, {31'd0, in_ready}, 32'd1);
    check({got.tag, "_idle_z"}, fp_z, got.z);
  endtask

  initial begin
    logic seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fp_x = 32'd0; fp_y = 32'd0; r_mode = 3'd0;
    #12;
    check("rst_inready", {31'd0, in_ready}, 32'd1);
    check("rst_outvalid", {31'd0, out_valid}, 32'd0);
    check("rst_z", fp_z, 32'd0);
    check("rst_ovrf", {31'd0, ovrf}, 32'd0);
    check("rst_udrf", {31'd0, udrf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("six_by_two",  32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 29, 0);
    do_op("third_rne",   32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 1'b0, 1'b0, 29, 0);
    do_op("third_rtz",   32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 1'b0, 1'b0, 0, 0);
    do_op("third_rup",   32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 1'b0, 1'b0, 0, 0);
    do_op("third_rdn",   32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 1'b0, 1'b0, 0, 0);
    do_op("third_rmm",   32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 1'b0, 1'b0, 0, 0);
    do_op("third_m111",  32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 1'b0, 1'b0, 0, 0);
    do_op("nthird_rdn",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 1'b0, 1'b0, 0, 0);
    do_op("nthird_rup",  32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 1'b0, 1'b0, 0, 0);
    do_op("div_by_zero", 32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 1, 0);
    do_op("zero_zero",   32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1, 0);
    do_op("negzero_num", 32'h80000000, 32'h40000000, 3'b000, 32'h80000000, 1'b0, 1'b0, 1, 0);
    do_op("subnorm_x",   32'h00400000, 32'h3F800000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1, 0);
    do_op("nan_x",       32'h7FC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1, 0);
    do_op("inf_by_num",  32'hFF800000, 32'h40000000, 3'b000, 32'hFF800000, 1'b0, 1'b0, 1, 0);
    do_op("num_by_inf",  32'h40000000, 32'hFF800000, 3'b000, 32'h80000000, 1'b0, 1'b0, 1, 0);
    do_op("ovf_rne",     32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 29, 0);
    do_op("ovf_rtz",     32'h7F000000, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 1'b1, 1'b0, 0, 0);
    do_op("novf_rup",    32'hFF000000, 32'h3E800000, 3'b011, 32'hFF7FFFFF, 1'b1, 1'b0, 0, 0);
    do_op("novf_rdn",    32'hFF000000, 32'h3E800000, 3'b010, 32'hFF800000, 1'b1, 1'b0, 0, 0);
    do_op("udf",         32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 1'b0, 1'b1, 29, 0);
    do_op("backpress",   32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 29, 5);

    // Reset during the tenth division cycle
    @(negedge clk);
    fp_x = 32'h3F800000; fp_y = 32'h40400000; r_mode = 3'b000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_inready", {31'd0, in_ready}, 32'd1);
    check("midrst_outvalid", {31'd0, out_valid}, 32'd0);
    check("midrst_z", fp_z, 32'd0);
    check("midrst_ovrf", {31'd0, ovrf}, 32'd0);
    check("midrst_udrf", {31'd0, udrf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_output", {31'd0, seen_valid}, 32'd0);
    check("midrst_idle_ready", {31'd0, in_ready}, 32'd1);

    do_op("after_rst",   32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 1'b0, 1'b0, 29, 0);
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
